// File: rtl/sal_sched_pkg.sv
// Shared command, refresh-state and DFI encoding definitions for the bank scheduler.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } sched_cmd_t;

  typedef enum logic [1:0] {
    S_NORM  = 2'd0,
    S_DRAIN = 2'd1,
    S_REF   = 2'd2,
    S_RFC   = 2'd3
  } ref_state_t;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] DFI_ACT = 3'b011;
  localparam logic [2:0] DFI_RD  = 3'b101;
  localparam logic [2:0] DFI_WR  = 3'b100;
  localparam logic [2:0] DFI_PRE = 3'b010;
  localparam logic [2:0] DFI_REF = 3'b001;
  localparam logic [2:0] DFI_NOP = 3'b111;

  // Map a scheduler command onto the DFI {ras_n, cas_n, we_n} triple.
  function automatic logic [2:0] f_dfi_enc(input sched_cmd_t c);
    logic [2:0] enc;
    case (c)
      CMD_ACT: enc = DFI_ACT;
      CMD_RD:  enc = DFI_RD;
      CMD_WR:  enc = DFI_WR;
      CMD_PRE: enc = DFI_PRE;
      CMD_REF: enc = DFI_REF;
      default: enc = DFI_NOP;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/sal_rr_arb.sv
// Round-robin arbiter: first request found searching upward from i_ptr, wrapping at N.
module sal_rr_arb #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic                 o_valid
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] w_idx;
  logic          w_found;

  // Rotating priority scan; N is a power of two so the index wraps naturally.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = i_ptr + PW'(k);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/sal_bk_sched.sv
// Multi-bank DRAM command scheduler: picks one bank command per cycle, enforces
// inter-bank timing, sequences refresh and drives a registered DFI command.
module sal_bk_sched
  import sal_sched_pkg::*;
#(
  parameter int unsigned BK_CNT = 8,
  parameter int unsigned ROW_AW = 14,
  parameter int unsigned COL_AW = 10,
  parameter int unsigned TW     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TW-1:0]              t_rrd_i,
  input  logic [TW-1:0]              t_ccd_i,
  input  logic [TW-1:0]              t_wtr_i,
  input  logic [TW-1:0]              t_rtw_i,
  input  logic [TW-1:0]              t_rfc_i,
  input  logic [BK_CNT-1:0]          req_valid_i,
  input  logic [BK_CNT*3-1:0]        req_cmd_i,
  input  logic [BK_CNT*ROW_AW-1:0]   req_row_i,
  input  logic [BK_CNT*COL_AW-1:0]   req_col_i,
  output logic [BK_CNT-1:0]          req_gnt_o,
  input  logic                       ref_req_i,
  input  logic                       all_bk_idle_i,
  output logic                       ref_gnt_o,
  output logic                       dfi_cs_n,
  output logic                       dfi_ras_n,
  output logic                       dfi_cas_n,
  output logic                       dfi_we_n,
  output logic [$clog2(BK_CNT)-1:0]  dfi_bank,
  output logic [ROW_AW-1:0]          dfi_address,
  output logic                       cas_rd_o,
  output logic                       cas_wr_o
);

  localparam int unsigned BW = $clog2(BK_CNT);
  // Column addresses never carry auto-precharge: A10 forced low when it exists.
  localparam logic [ROW_AW-1:0] L_A10_CLR = ~(ROW_AW'(1) << 10);

  sched_cmd_t        w_cmd [BK_CNT];
  logic [ROW_AW-1:0] w_row [BK_CNT];
  logic [COL_AW-1:0] w_col [BK_CNT];

  ref_state_t  r_state, w_state_nxt;
  logic [TW-1:0] r_rrd, r_ccd, r_wtr, r_rtw, r_rfc;
  logic [BW-1:0] r_ptr_cas, r_ptr_act, r_ptr_pre;

  logic              w_blk, w_rd_ok, w_wr_ok, w_act_ok;
  logic [BK_CNT-1:0] w_cas_req, w_act_req, w_pre_req;
  logic [BK_CNT-1:0] w_cas_gnt, w_act_gnt, w_pre_gnt;
  logic              w_cas_vld, w_act_vld, w_pre_vld;
  logic              w_sel_cas, w_sel_act, w_sel_pre, w_any;
  logic [BK_CNT-1:0] w_gnt;
  logic [BW-1:0]     w_gnt_idx;
  sched_cmd_t        w_gnt_cmd;
  logic              w_iss_act, w_iss_rd, w_iss_wr;

  logic              w_cs_n_nxt, w_ref_gnt_nxt, w_cas_rd_nxt, w_cas_wr_nxt;
  logic [2:0]        w_rcw_nxt;
  logic [BW-1:0]     w_bank_nxt;
  logic [ROW_AW-1:0] w_addr_nxt;

  function automatic logic [TW-1:0] f_load(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic [TW-1:0] f_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Split the flat per-bank request buses into arrays.
  for (genvar g = 0; g < BK_CNT; g++) begin : g_unpack
    assign w_cmd[g] = sched_cmd_t'(req_cmd_i[g*3 +: 3]);
    assign w_row[g] = req_row_i[g*ROW_AW +: ROW_AW];
    assign w_col[g] = req_col_i[g*COL_AW +: COL_AW];
  end

  assign w_blk    = (r_state == S_REF) || (r_state == S_RFC);
  assign w_rd_ok  = !w_blk && (r_ccd == '0) && (r_wtr == '0);
  assign w_wr_ok  = !w_blk && (r_ccd == '0) && (r_rtw == '0);
  assign w_act_ok = (r_state == S_NORM) && (r_rrd == '0);

  // Per-class eligible request vectors.
  always_comb begin
    w_cas_req = '0;
    w_act_req = '0;
    w_pre_req = '0;
    for (int unsigned i = 0; i < BK_CNT; i++) begin
      w_cas_req[i] = req_valid_i[i] &&
                     (((w_cmd[i] == CMD_RD) && w_rd_ok) || ((w_cmd[i] == CMD_WR) && w_wr_ok));
      w_act_req[i] = req_valid_i[i] && (w_cmd[i] == CMD_ACT) && w_act_ok;
      w_pre_req[i] = req_valid_i[i] && (w_cmd[i] == CMD_PRE) && !w_blk;
    end
  end

  sal_rr_arb #(.N(BK_CNT)) u_arb_cas (
    .i_req(w_cas_req), .i_ptr(r_ptr_cas), .o_gnt(w_cas_gnt), .o_valid(w_cas_vld)
  );

  sal_rr_arb #(.N(BK_CNT)) u_arb_act (
    .i_req(w_act_req), .i_ptr(r_ptr_act), .o_gnt(w_act_gnt), .o_valid(w_act_vld)
  );

  sal_rr_arb #(.N(BK_CNT)) u_arb_pre (
    .i_req(w_pre_req), .i_ptr(r_ptr_pre), .o_gnt(w_pre_gnt), .o_valid(w_pre_vld)
  );

  assign w_sel_cas = w_cas_vld;
  assign w_sel_act = !w_cas_vld && w_act_vld;
  assign w_sel_pre = !w_cas_vld && !w_act_vld && w_pre_vld;
  assign w_any     = w_sel_cas || w_sel_act || w_sel_pre;

  // Class priority CAS > ACT > PRE, then one-hot to index.
  always_comb begin
    w_gnt = '0;
    if (w_sel_cas)      w_gnt = w_cas_gnt;
    else if (w_sel_act) w_gnt = w_act_gnt;
    else if (w_sel_pre) w_gnt = w_pre_gnt;
    w_gnt_idx = '0;
    for (int unsigned i = 0; i < BK_CNT; i++) begin
      if (w_gnt[i]) w_gnt_idx = BW'(i);
    end
  end

  assign req_gnt_o = w_gnt;
  assign w_gnt_cmd = w_any ? w_cmd[w_gnt_idx] : CMD_NOP;
  assign w_iss_act = w_any && (w_gnt_cmd == CMD_ACT);
  assign w_iss_rd  = w_any && (w_gnt_cmd == CMD_RD);
  assign w_iss_wr  = w_any && (w_gnt_cmd == CMD_WR);

  // Refresh FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_NORM;
    else     r_state <= w_state_nxt;
  end

  // Refresh FSM next state; S_RFC exits as the tRFC counter reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NORM:  if (ref_req_i) w_state_nxt = S_DRAIN;
      S_DRAIN: if (all_bk_idle_i) w_state_nxt = S_REF;
      S_REF:   w_state_nxt = S_RFC;
      S_RFC:   if (r_rfc <= TW'(1)) w_state_nxt = S_NORM;
      default: w_state_nxt = S_NORM;
    endcase
  end

  // Inter-bank timers: load t-1 on issue, otherwise count down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrd <= '0;
      r_ccd <= '0;
      r_wtr <= '0;
      r_rtw <= '0;
      r_rfc <= '0;
    end else begin
      r_rrd <= w_iss_act ? f_load(t_rrd_i) : f_dec(r_rrd);
      r_ccd <= (w_iss_rd || w_iss_wr) ? f_load(t_ccd_i) : f_dec(r_ccd);
      r_wtr <= w_iss_wr ? f_load(t_wtr_i) : f_dec(r_wtr);
      r_rtw <= w_iss_rd ? f_load(t_rtw_i) : f_dec(r_rtw);
      r_rfc <= (r_state == S_REF) ? f_load(t_rfc_i) : f_dec(r_rfc);
    end
  end

  // Round-robin pointers move past the bank just granted in their class.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr_cas <= '0;
      r_ptr_act <= '0;
      r_ptr_pre <= '0;
    end else begin
      if (w_sel_cas) r_ptr_cas <= w_gnt_idx + BW'(1);
      if (w_sel_act) r_ptr_act <= w_gnt_idx + BW'(1);
      if (w_sel_pre) r_ptr_pre <= w_gnt_idx + BW'(1);
    end
  end

  // Next DFI command; bank/address hold on idle cycles.
  always_comb begin
    w_cs_n_nxt    = 1'b1;
    w_rcw_nxt     = DFI_NOP;
    w_bank_nxt    = dfi_bank;
    w_addr_nxt    = dfi_address;
    w_ref_gnt_nxt = 1'b0;
    w_cas_rd_nxt  = 1'b0;
    w_cas_wr_nxt  = 1'b0;
    if (r_state == S_REF) begin
      w_cs_n_nxt    = 1'b0;
      w_rcw_nxt     = DFI_REF;
      w_bank_nxt    = '0;
      w_addr_nxt    = '0;
      w_ref_gnt_nxt = 1'b1;
    end else if (w_any) begin
      w_cs_n_nxt = 1'b0;
      w_rcw_nxt  = f_dfi_enc(w_gnt_cmd);
      w_bank_nxt = w_gnt_idx;
      case (w_gnt_cmd)
        CMD_ACT: w_addr_nxt = w_row[w_gnt_idx];
        CMD_RD: begin
          w_addr_nxt   = ROW_AW'(w_col[w_gnt_idx]) & L_A10_CLR;
          w_cas_rd_nxt = 1'b1;
        end
        CMD_WR: begin
          w_addr_nxt   = ROW_AW'(w_col[w_gnt_idx]) & L_A10_CLR;
          w_cas_wr_nxt = 1'b1;
        end
        default: w_addr_nxt = '0;
      endcase
    end
  end

  // Registered DFI command and side-band pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dfi_cs_n    <= 1'b1;
      dfi_ras_n   <= 1'b1;
      dfi_cas_n   <= 1'b1;
      dfi_we_n    <= 1'b1;
      dfi_bank    <= '0;
      dfi_address <= '0;
      ref_gnt_o   <= 1'b0;
      cas_rd_o    <= 1'b0;
      cas_wr_o    <= 1'b0;
    end else begin
      dfi_cs_n                          <= w_cs_n_nxt;
      {dfi_ras_n, dfi_cas_n, dfi_we_n}  <= w_rcw_nxt;
      dfi_bank                          <= w_bank_nxt;
      dfi_address                       <= w_addr_nxt;
      ref_gnt_o                         <= w_ref_gnt_nxt;
      cas_rd_o                          <= w_cas_rd_nxt;
      cas_wr_o                          <= w_cas_wr_nxt;
    end
  end

endmodule

// File: tb/tb_sal_bk_sched.sv
// Directed testbench for sal_bk_sched with hand-computed expectations.
module tb_sal_bk_sched;
  import sal_sched_pkg::*;

  localparam logic [3:0] C_NOP = 4'b1111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   t_rrd, t_ccd, t_wtr, t_rtw, t_rfc;
  logic [7:0]   req_valid;
  logic [23:0]  req_cmd;
  logic [111:0] req_row;
  logic [79:0]  req_col;
  logic [7:0]   req_gnt;
  logic         ref_req, all_idle, ref_gnt;
  logic         cs_n, ras_n, cas_n, we_n;
  logic [2:0]   dfi_bank;
  logic [13:0]  dfi_addr;
  logic         cas_rd, cas_wr;

  logic [7:0]   last_gnt;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  sal_bk_sched #(.BK_CNT(8), .ROW_AW(14), .COL_AW(10), .TW(8)) dut (
    .clk(clk), .rst(rst),
    .t_rrd_i(t_rrd), .t_ccd_i(t_ccd), .t_wtr_i(t_wtr), .t_rtw_i(t_rtw), .t_rfc_i(t_rfc),
    .req_valid_i(req_valid), .req_cmd_i(req_cmd), .req_row_i(req_row), .req_col_i(req_col),
    .req_gnt_o(req_gnt), .ref_req_i(ref_req), .all_bk_idle_i(all_idle), .ref_gnt_o(ref_gnt),
    .dfi_cs_n(cs_n), .dfi_ras_n(ras_n), .dfi_cas_n(cas_n), .dfi_we_n(we_n),
    .dfi_bank(dfi_bank), .dfi_address(dfi_addr), .cas_rd_o(cas_rd), .cas_wr_o(cas_wr)
  );

  function automatic logic [3:0] dfi_now();
    return {cs_n, ras_n, cas_n, we_n};
  endfunction

  task automatic set_req(input int b, input sched_cmd_t c, input logic [13:0] row,
                         input logic [9:0] col);
    req_valid[b]         = 1'b1;
    req_cmd[b*3 +: 3]    = c;
    req_row[b*14 +: 14]  = row;
    req_col[b*10 +: 10]  = col;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_cmd = '0; req_row = '0; req_col = '0;
    ref_req = 1'b0; all_idle = 1'b0; last_gnt = '0;
    t_rrd = 8'd1; t_ccd = 8'd1; t_wtr = 8'd1; t_rtw = 8'd1; t_rfc = 8'd1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_cmd = '0; req_row = '0; req_col = '0;
    ref_req = 1'b0; all_idle = 1'b0;
    t_rrd = 8'd1; t_ccd = 8'd1; t_wtr = 8'd1; t_rtw = 8'd1; t_rfc = 8'd1;
    #2;
    checks++; if (dfi_now() !== C_NOP) begin errors++; $display("FAIL reset_cmd: got %b exp %b", dfi_now(), C_NOP); end
    checks++; if (dfi_bank !== 3'd0) begin errors++; $display("FAIL reset_bank: got %0d exp 0", dfi_bank); end
    checks++; if (dfi_addr !== 14'd0) begin errors++; $display("FAIL reset_addr: got %h exp 0", dfi_addr); end
    checks++; if ({ref_gnt, cas_rd, cas_wr} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b exp 000", {ref_gnt, cas_rd, cas_wr}); end
    checks++; if (req_gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h exp 00", req_gnt); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (dfi_now() !== C_NOP) begin errors++; $display("FAIL idle_cmd: got %b exp %b", dfi_now(), C_NOP); end
  endtask

  // Banks 0 and 3 ACT together with tRRD=3.
  task automatic test_act_rrd();
    logic [7:0] exp_gnt [6];
    logic [3:0] exp_cmd [6];
    exp_gnt[0] = 8'h01; exp_gnt[1] = 8'h00; exp_gnt[2] = 8'h00;
    exp_gnt[3] = 8'h08; exp_gnt[4] = 8'h00; exp_gnt[5] = 8'h00;
    exp_cmd[0] = C_NOP; exp_cmd[1] = C_ACT; exp_cmd[2] = C_NOP;
    exp_cmd[3] = C_NOP; exp_cmd[4] = C_ACT; exp_cmd[5] = C_NOP;
    do_reset();
    t_rrd = 8'd3;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      req_valid = req_valid & ~last_gnt;
      if (s == 0) begin
        set_req(0, CMD_ACT, 14'h0123, 10'h0);
        set_req(3, CMD_ACT, 14'h2abc, 10'h0);
      end
      #1;
      checks++; if (req_gnt !== exp_gnt[s]) begin errors++; $display("FAIL act_rrd_gnt s%0d: got %h exp %h", s, req_gnt, exp_gnt[s]); end
      checks++; if (dfi_now() !== exp_cmd[s]) begin errors++; $display("FAIL act_rrd_cmd s%0d: got %b exp %b", s, dfi_now(), exp_cmd[s]); end
      if (s == 1 || s == 2) begin
        checks++; if ({dfi_bank, dfi_addr} !== {3'd0, 14'h0123}) begin errors++; $display("FAIL act_rrd_addr0 s%0d: got %0d/%h exp 0/0123", s, dfi_bank, dfi_addr); end
      end
      if (s == 4) begin
        checks++; if ({dfi_bank, dfi_addr} !== {3'd3, 14'h2abc}) begin errors++; $display("FAIL act_rrd_addr3: got %0d/%h exp 3/2abc", dfi_bank, dfi_addr); end
      end
      last_gnt = req_gnt;
    end
  endtask

  // Banks 1,2,5 hold RD, tCCD=2: round-robin one RD every other cycle.
  task automatic test_rd_rr();
    logic [7:0] exp_gnt [8];
    int         exp_bank [8];
    exp_gnt[0] = 8'h02; exp_gnt[1] = 8'h00; exp_gnt[2] = 8'h04; exp_gnt[3] = 8'h00;
    exp_gnt[4] = 8'h20; exp_gnt[5] = 8'h00; exp_gnt[6] = 8'h02; exp_gnt[7] = 8'h00;
    exp_bank[0] = -1; exp_bank[1] = 1; exp_bank[2] = -1; exp_bank[3] = 2;
    exp_bank[4] = -1; exp_bank[5] = 5; exp_bank[6] = -1; exp_bank[7] = 1;
    do_reset();
    t_ccd = 8'd2;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      if (s == 0) begin
        set_req(1, CMD_RD, 14'h0, 10'h011);
        set_req(2, CMD_RD, 14'h0, 10'h022);
        set_req(5, CMD_RD, 14'h0, 10'h055);
      end
      #1;
      checks++; if (req_gnt !== exp_gnt[s]) begin errors++; $display("FAIL rd_rr_gnt s%0d: got %h exp %h", s, req_gnt, exp_gnt[s]); end
      checks++; if (cas_rd !== (exp_bank[s] >= 0)) begin errors++; $display("FAIL rd_rr_casrd s%0d: got %b exp %b", s, cas_rd, exp_bank[s] >= 0); end
      if (exp_bank[s] >= 0) begin
        checks++; if ({dfi_now(), dfi_bank} !== {C_RD, 3'(exp_bank[s])}) begin errors++; $display("FAIL rd_rr_cmd s%0d: got %b/%0d exp %b/%0d", s, dfi_now(), dfi_bank, C_RD, exp_bank[s]); end
        checks++; if (dfi_addr !== 14'(exp_bank[s] * 17)) begin errors++; $display("FAIL rd_rr_addr s%0d: got %h exp %h", s, dfi_addr, 14'(exp_bank[s] * 17)); end
      end
    end
  endtask

  // WR->RD with tWTR=4, then RD->WR with tRTW=3.
  task automatic test_wtr_rtw();
    logic [7:0] exp_gnt [9];
    logic [3:0] exp_cmd [9];
    for (int s = 0; s < 9; s++) begin exp_gnt[s] = 8'h00; exp_cmd[s] = C_NOP; end
    exp_gnt[0] = 8'h01; exp_gnt[4] = 8'h02; exp_gnt[7] = 8'h01;
    exp_cmd[1] = C_WR;  exp_cmd[5] = C_RD;  exp_cmd[8] = C_WR;
    do_reset();
    t_wtr = 8'd4; t_rtw = 8'd3; t_ccd = 8'd1;
    for (int s = 0; s < 9; s++) begin
      @(negedge clk);
      req_valid = req_valid & ~last_gnt;
      if (s == 0) begin
        set_req(0, CMD_WR, 14'h0, 10'h3ff);
        set_req(1, CMD_RD, 14'h0, 10'h123);
      end
      if (s == 5) set_req(0, CMD_WR, 14'h0, 10'h2aa);
      #1;
      checks++; if (req_gnt !== exp_gnt[s]) begin errors++; $display("FAIL wtr_rtw_gnt s%0d: got %h exp %h", s, req_gnt, exp_gnt[s]); end
      checks++; if (dfi_now() !== exp_cmd[s]) begin errors++; $display("FAIL wtr_rtw_cmd s%0d: got %b exp %b", s, dfi_now(), exp_cmd[s]); end
      checks++; if ({cas_rd, cas_wr} !== {exp_cmd[s] == C_RD, exp_cmd[s] == C_WR}) begin errors++; $display("FAIL wtr_rtw_pulse s%0d: got %b%b", s, cas_rd, cas_wr); end
      if (s == 1) begin
        checks++; if (dfi_addr !== 14'h03ff) begin errors++; $display("FAIL wtr_addr_wr: got %h exp 03ff", dfi_addr); end
      end
      if (s == 5) begin
        checks++; if ({dfi_bank, dfi_addr} !== {3'd1, 14'h0123}) begin errors++; $display("FAIL wtr_addr_rd: got %0d/%h exp 1/0123", dfi_bank, dfi_addr); end
      end
      if (s == 8) begin
        checks++; if ({dfi_bank, dfi_addr} !== {3'd0, 14'h02aa}) begin errors++; $display("FAIL rtw_addr_wr: got %0d/%h exp 0/02aa", dfi_bank, dfi_addr); end
      end
      last_gnt = req_gnt;
    end
  endtask

  // RD beats ACT beats PRE when all are eligible together.
  task automatic test_cas_over_act();
    logic [7:0] exp_gnt [4];
    logic [3:0] exp_cmd [4];
    exp_gnt[0] = 8'h10; exp_gnt[1] = 8'h04; exp_gnt[2] = 8'h80; exp_gnt[3] = 8'h00;
    exp_cmd[0] = C_NOP; exp_cmd[1] = C_RD;  exp_cmd[2] = C_ACT; exp_cmd[3] = C_PRE;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      req_valid = req_valid & ~last_gnt;
      if (s == 0) begin
        set_req(2, CMD_ACT, 14'h1555, 10'h0);
        set_req(4, CMD_RD,  14'h0,    10'h044);
        set_req(7, CMD_PRE, 14'h0,    10'h0);
      end
      #1;
      checks++; if (req_gnt !== exp_gnt[s]) begin errors++; $display("FAIL prio_gnt s%0d: got %h exp %h", s, req_gnt, exp_gnt[s]); end
      checks++; if (dfi_now() !== exp_cmd[s]) begin errors++; $display("FAIL prio_cmd s%0d: got %b exp %b", s, dfi_now(), exp_cmd[s]); end
      if (s == 1) begin
        checks++; if ({dfi_bank, dfi_addr} !== {3'd4, 14'h0044}) begin errors++; $display("FAIL prio_addr_rd: got %0d/%h exp 4/0044", dfi_bank, dfi_addr); end
      end
      if (s == 2) begin
        checks++; if ({dfi_bank, dfi_addr} !== {3'd2, 14'h1555}) begin errors++; $display("FAIL prio_addr_act: got %0d/%h exp 2/1555", dfi_bank, dfi_addr); end
      end
      if (s == 3) begin
        checks++; if ({dfi_bank, dfi_addr} !== {3'd7, 14'h0000}) begin errors++; $display("FAIL prio_addr_pre: got %0d/%h exp 7/0000", dfi_bank, dfi_addr); end
      end
      last_gnt = req_gnt;
    end
  endtask

  // Refresh: drain masks ACT, REF issued, tRFC=10 holds off the next command.
  task automatic test_refresh();
    logic [7:0] exp_gnt [19];
    logic [3:0] exp_cmd [19];
    for (int s = 0; s < 19; s++) begin exp_gnt[s] = 8'h00; exp_cmd[s] = C_NOP; end
    exp_gnt[0] = 8'h40; exp_gnt[2] = 8'h02; exp_gnt[17] = 8'h40;
    exp_cmd[1] = C_ACT; exp_cmd[3] = C_RD; exp_cmd[8] = C_REF; exp_cmd[18] = C_ACT;
    do_reset();
    t_rfc = 8'd10;
    for (int s = 0; s < 19; s++) begin
      @(negedge clk);
      req_valid = req_valid & ~last_gnt;
      if (s == 0) begin
        ref_req = 1'b1;
        set_req(6, CMD_ACT, 14'h0666, 10'h0);
      end
      if (s == 1) set_req(6, CMD_ACT, 14'h0999, 10'h0);
      if (s == 2) set_req(1, CMD_RD, 14'h0, 10'h011);
      if (s == 6) all_idle = 1'b1;
      if (s == 8) begin ref_req = 1'b0; all_idle = 1'b0; end
      #1;
      checks++; if (req_gnt !== exp_gnt[s]) begin errors++; $display("FAIL ref_gnt_vec s%0d: got %h exp %h", s, req_gnt, exp_gnt[s]); end
      checks++; if (dfi_now() !== exp_cmd[s]) begin errors++; $display("FAIL ref_cmd s%0d: got %b exp %b", s, dfi_now(), exp_cmd[s]); end
      checks++; if (ref_gnt !== (s == 8)) begin errors++; $display("FAIL ref_pulse s%0d: got %b exp %b", s, ref_gnt, s == 8); end
      if (s == 8) begin
        checks++; if ({dfi_bank, dfi_addr} !== {3'd0, 14'h0000}) begin errors++; $display("FAIL ref_addr: got %0d/%h exp 0/0000", dfi_bank, dfi_addr); end
      end
      if (s == 18) begin
        checks++; if ({dfi_bank, dfi_addr} !== {3'd6, 14'h0999}) begin errors++; $display("FAIL ref_act_after: got %0d/%h exp 6/0999", dfi_bank, dfi_addr); end
      end
      last_gnt = req_gnt;
    end
  endtask

  // Asynchronous reset while in S_RFC, then normal ACT service resumes.
  task automatic test_rst_in_rfc();
    do_reset();
    t_rfc = 8'd20;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      if (s == 0) begin ref_req = 1'b1; all_idle = 1'b1; end
      if (s == 1) set_req(3, CMD_ACT, 14'h0777, 10'h0);
      #1;
      checks++; if (req_gnt !== 8'h00) begin errors++; $display("FAIL rfc_rst_gnt s%0d: got %h exp 00", s, req_gnt); end
    end
    checks++; if ({dfi_now(), ref_gnt} !== {C_REF, 1'b1}) begin errors++; $display("FAIL rfc_rst_ref: got %b/%b exp %b/1", dfi_now(), ref_gnt, C_REF); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({dfi_now(), ref_gnt} !== {C_NOP, 1'b0}) begin errors++; $display("FAIL rfc_rst_async: got %b/%b exp %b/0", dfi_now(), ref_gnt, C_NOP); end
    ref_req = 1'b0; all_idle = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_gnt !== 8'h08) begin errors++; $display("FAIL rfc_rst_actgnt: got %h exp 08", req_gnt); end
    last_gnt = req_gnt;
    @(negedge clk);
    req_valid = req_valid & ~last_gnt;
    #1;
    checks++; if ({dfi_now(), dfi_bank, dfi_addr} !== {C_ACT, 3'd3, 14'h0777}) begin errors++; $display("FAIL rfc_rst_act: got %b/%0d/%h exp %b/3/0777", dfi_now(), dfi_bank, dfi_addr, C_ACT); end
  endtask

  initial begin
    test_reset();
    test_act_rrd();
    test_rd_rr();
    test_wtr_rtw();
    test_cas_over_act();
    test_refresh();
    test_rst_in_rfc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
